// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
//   Shared definitions for the ADC acquisition slice: FSM state encoding,
//   ADC result width and a counter-width helper.
// ---------------------------------------------------------------------------
package adc_pkg;

   localparam int unsigned ADC_DATA_W = 12;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_CONV = 2'd2,
      S_CAPT = 2'd3
   } state_e;

   // Bits needed to hold 0..n-1 (never less than one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adc_settle_timer.sv
// ---------------------------------------------------------------------------
// adc_settle_timer
//   Settle timer requested by the ADC receiver. Counts clock cycles while
//   en_i is high (saturating) and raises finish_o once the count has reached
//   SETTLE_CYCLES. Dropping en_i clears the count and finish_o next cycle.
// Ports
//   clk_i     clock, posedge
//   rst_ni    asynchronous active-low reset
//   en_i      settle request (En_temp)
//   finish_o  registered settle-expired flag (temp_finish)
// ---------------------------------------------------------------------------
module adc_settle_timer
   import adc_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic finish_o
);

   localparam int unsigned CW = cnt_w(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] SAT = CW'(SETTLE_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          fin_q, fin_d;

   always_comb begin
      cnt_d = '0;
      fin_d = 1'b0;
      if (en_i) begin
         cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
         fin_d = (cnt_q >= SAT);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         fin_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         fin_q <= fin_d;
      end
   end

   assign finish_o = fin_q;

endmodule

// File: rtl/adc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// adc_sample_scheduler
//   Periodic acquisition sequencer for the serial ADC receiver (ADC_3).
//   Starts a conversion every PERIOD cycles, aborts conversions that exceed
//   TIMEOUT cycles, runs the settle timer and latches results into a holding
//   register with a valid/ack handshake and sticky overrun/timeout flags.
//   Build option: define ADC_AVG_EN to average 2^AVG_LOG2 results per update.
// Ports
//   SCLK          clock, all logic on posedge
//   reset         asynchronous active-low reset
//   enable        1 = periodic acquisition; 0 = finish conversion then idle
//   rx_en         conversion request, high for the whole conversion
//   En_temp       settle-timer request from ADC_3
//   temp_finish   settle timer expired
//   rx_done_tick  one-cycle pulse, adc_data valid
//   adc_data      ADC_3 result
//   sample        latched result
//   sample_valid  sample holds an unconsumed result
//   sample_ack    consumer takes sample
//   overrun       sticky: result arrived over an unconsumed sample
//   timeout_err   sticky: conversion aborted on timeout
//   err_clr       clears overrun and timeout_err
// ---------------------------------------------------------------------------
module adc_sample_scheduler
   import adc_pkg::*;
#(
   parameter int unsigned PERIOD        = 1024,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned TIMEOUT       = 64,
   parameter int unsigned AVG_LOG2      = 2
) (
   input  logic                  SCLK,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  rx_en,
   input  logic                  En_temp,
   output logic                  temp_finish,
   input  logic                  rx_done_tick,
   input  logic [ADC_DATA_W-1:0] adc_data,
   output logic [ADC_DATA_W-1:0] sample,
   output logic                  sample_valid,
   input  logic                  sample_ack,
   output logic                  overrun,
   output logic                  timeout_err,
   input  logic                  err_clr
);

   if (PERIOD < 64 || TIMEOUT < 20 || SETTLE_CYCLES < 1 || AVG_LOG2 > 4) begin : g_param_check
      $error("adc_sample_scheduler: parameter out of range");
   end

   localparam int unsigned PW = cnt_w(PERIOD);
   localparam int unsigned TW = cnt_w(TIMEOUT);
   localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_e                state_q, state_d;
   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [ADC_DATA_W-1:0] data_q, data_d;
   logic                  rx_en_q, rx_en_d;
   logic [ADC_DATA_W-1:0] sample_q, sample_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;
   logic                  tmo_q, tmo_d;

   logic                  period_hit;
   logic                  capt;
   logic                  abort;
   logic                  upd;
   logic [ADC_DATA_W-1:0] upd_val;
   logic                  ovr_ev;

`ifdef ADC_AVG_EN
   localparam logic [3:0] IDX_LAST = 4'((1 << AVG_LOG2) - 1);
   logic [15:0] acc_q, acc_d, acc_sum;
   logic [3:0]  idx_q, idx_d;
`endif

   assign period_hit = (pcnt_q == P_LAST);
   assign capt       = (state_q == S_CAPT);
   assign abort      = (state_q == S_CONV) && !rx_done_tick && (tcnt_q == T_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge SCLK or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // Period expiry while in CONV is deliberately ignored (that start is skipped).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (enable) state_d = S_WAIT;
         S_WAIT: begin
            if (!enable)         state_d = S_IDLE;
            else if (period_hit) state_d = S_CONV;
         end
         S_CONV: begin
            if (rx_done_tick)          state_d = S_CAPT;
            else if (tcnt_q == T_LAST) state_d = S_WAIT;
         end
         S_CAPT:  state_d = enable ? S_WAIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM outputs / datapath next state ----------------
   always_comb begin
      // Period counter keeps running through CONV/CAPT so start spacing is exact.
      if (state_q == S_IDLE || state_d == S_IDLE) pcnt_d = '0;
      else if (period_hit)                        pcnt_d = '0;
      else                                        pcnt_d = pcnt_q + 1'b1;

      tcnt_d  = (state_q == S_CONV) ? tcnt_q + 1'b1 : '0;
      rx_en_d = (state_d == S_CONV);

      // Result is taken on the done tick itself and written to sample in CAPT.
      data_d = (state_q == S_CONV && rx_done_tick) ? adc_data : data_q;

      upd     = 1'b0;
      upd_val = data_q;
`ifdef ADC_AVG_EN
      acc_d   = acc_q;
      idx_d   = idx_q;
      acc_sum = acc_q + 16'(data_q);
      if (capt) begin
         if (idx_q == IDX_LAST) begin
            upd     = 1'b1;
            upd_val = ADC_DATA_W'(acc_sum >> AVG_LOG2);
            acc_d   = '0;
            idx_d   = '0;
         end else begin
            acc_d = acc_sum;
            idx_d = idx_q + 1'b1;
         end
      end else if (abort || (state_q == S_IDLE && !enable)) begin
         acc_d = '0;
         idx_d = '0;
      end
`else
      upd = capt;
`endif

      sample_d = sample_q;
      valid_d  = valid_q;
      ovr_ev   = 1'b0;
      if (upd) begin
         // A simultaneous ack consumes the old value, so no overrun and valid stays set.
         sample_d = upd_val;
         valid_d  = 1'b1;
         ovr_ev   = valid_q && !sample_ack;
      end else if (sample_ack) begin
         valid_d = 1'b0;
      end

      // A new error event in the clear cycle wins over err_clr.
      ovr_d = ovr_ev | (ovr_q & ~err_clr);
      tmo_d = abort  | (tmo_q & ~err_clr);
   end

   always_ff @(posedge SCLK or negedge reset) begin
      if (!reset) begin
         pcnt_q   <= '0;
         tcnt_q   <= '0;
         data_q   <= '0;
         rx_en_q  <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         tcnt_q   <= tcnt_d;
         data_q   <= data_d;
         rx_en_q  <= rx_en_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         tmo_q    <= tmo_d;
      end
   end

`ifdef ADC_AVG_EN
   always_ff @(posedge SCLK or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end
`endif

   adc_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle (
      .clk_i   (SCLK),
      .rst_ni  (reset),
      .en_i    (En_temp),
      .finish_o(temp_finish)
   );

   assign rx_en        = rx_en_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;
   assign timeout_err  = tmo_q;

endmodule
